multicycle_controller: RTL and testbench

Multicycle MIPS control unit: an FSM sequences each instruction over 3–5 states (plus memory wait cycles) and drives the shared-datapath control signals. It sits beside the multicycle datapath. It accepts `opcode` from the IR and `zero` from the ALU, and it supports an optional memory ready handshake. A retired-instruction counter is exposed for test and performance checks.

---
 rtl/multicycle_controller.sv | 175 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences each instruction over FETCH..writeback and drives datapath controls.
// Outputs are combinational from state (plus zero/mem_ready); memory states stall while mem_ready is low.
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             sel_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JUMP
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_JR   = 6'b000001;

  state_t           r_state;
  state_t           w_next;
  logic             w_ready;
  logic             w_retire;
  logic [CNT_W-1:0] r_instr_retired;

  assign w_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
  // The only DECODE->FETCH edge is the illegal path, which must not count.
  assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_DECODE);
  assign instr_retired = r_instr_retired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_FETCH;
      r_instr_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire)
        r_instr_retired <= r_instr_retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (w_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:       w_next = S_MEM_ADDR;
          OP_R:               w_next = S_EXEC_R;
          OP_ADDI, OP_ANDI:   w_next = S_EXEC_I;
          OP_BEQ, OP_BNE:     w_next = S_BRANCH;
          OP_J, OP_JAL, OP_JR: w_next = S_JUMP;
          default:            w_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR: w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (w_ready) w_next = S_MEM_WB;
      S_MEM_WR:   if (w_ready) w_next = S_FETCH;
      S_EXEC_R,
      S_EXEC_I:   w_next = S_ALU_WB;
      S_MEM_WB,
      S_ALU_WB,
      S_BRANCH,
      S_JUMP:     w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    sel_reg    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 2'b01;
        ir_write  = w_ready;
        pc_write  = w_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = 2'b01;
        case (opcode)
          OP_R, OP_ADDI, OP_ANDI, OP_LW, OP_SW,
          OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_JR: illegal = 1'b0;
          default:                             illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b01;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_ANDI) ? 2'b11 : 2'b01;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_R);
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        pc_source = 2'b01;
        pc_write  = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        if (opcode == OP_JR) begin
          pc_source = 2'b11;
        end else begin
          pc_source = 2'b10;
          reg_write = (opcode == OP_JAL);
          sel_reg   = (opcode == OP_JAL);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: per-cycle vector table for the main sequences, plus hand-written reset and wrap cases.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw, irw, iord, mr, mw, rw, rd, m2r, sr, sa;
    logic [1:0] sb, op, ps;
    logic       ill;
  } ctrl_t;

  typedef struct {
    logic [5:0]  opc;
    logic        z;
    logic        rdy;
    ctrl_t       exp;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, zero, mem_ready;
  logic [5:0] opcode;
  logic pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, sel_reg, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [15:0] instr_retired;

  logic rst2_n, mem_ready2;
  logic [5:0] opcode2;
  logic pcw2, irw2, iord2, mr2, mw2, rw2, rd2, m2r2, sr2, sa2, ill2;
  logic [1:0] sb2, op2, ps2;
  logic [1:0] cnt2;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .sel_reg(sel_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal(illegal), .instr_retired(instr_retired)
  );

  multicycle_controller #(.MEM_HANDSHAKE(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .opcode(opcode2), .zero(1'b0), .mem_ready(mem_ready2),
    .pc_write(pcw2), .ir_write(irw2), .iord(iord2), .mem_read(mr2), .mem_write(mw2),
    .reg_write(rw2), .reg_dst(rd2), .mem_to_reg(m2r2), .sel_reg(sr2),
    .alu_src_a(sa2), .alu_src_b(sb2), .alu_op(op2), .pc_source(ps2),
    .illegal(ill2), .instr_retired(cnt2)
  );

  function automatic ctrl_t mk(input logic pcw, irw, iord_i, mr, mw, rw, rd, m2r, sr, sa,
                               input logic [1:0] sb, op, ps, input logic ill);
    ctrl_t c;
    c = '{pcw, irw, iord_i, mr, mw, rw, rd, m2r, sr, sa, sb, op, ps, ill};
    return c;
  endfunction

  function automatic ctrl_t actual();
    ctrl_t c;
    c = '{pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
          sel_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal};
    return c;
  endfunction

  task automatic chk(input string tag, input int idx, input ctrl_t exp, input logic [15:0] ecnt);
    ctrl_t a;
    a = actual();
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s[%0d] ctrl: got %b want %b", tag, idx, a, exp);
    end
    checks++;
    if (instr_retired !== ecnt) begin
      errors++;
      $display("FAIL %s[%0d] instr_retired: got %0d want %0d", tag, idx, instr_retired, ecnt);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] ecnt, input logic eirw);
    checks++;
    if (cnt2 !== ecnt || irw2 !== eirw) begin
      errors++;
      $display("FAIL %s: got cnt=%0d ir_write=%b want cnt=%0d ir_write=%b", tag, cnt2, irw2, ecnt, eirw);
    end
  endtask

  task automatic add(input logic [5:0] o, input logic z, input logic r, input ctrl_t e, input int c);
    vec_t v;
    v.opc = o; v.z = z; v.rdy = r; v.exp = e; v.cnt = 16'(c);
    tbl.push_back(v);
  endtask

  ctrl_t F1, F0, DEC, DILL, MADR, MRD, MWB, MWR, EXR, EXADD, EXAND, WBR, WBI, BRT, BRN, JJ, JAL, JR;

  initial begin
    //        pcw irw iord mr mw rw rd m2r sr sa  sb     op     ps     ill
    F1    = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 0);
    F0    = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 0);
    DEC   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, 0);
    DILL  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, 1);
    MADR  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b00, 0);
    MRD   = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    MWB   = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    MWR   = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    EXR   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0);
    EXADD = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b00, 0);
    EXAND = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b11, 2'b00, 0);
    WBR   = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    WBI   = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
    BRT   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b01, 0);
    BRN   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b01, 0);
    JJ    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
    JAL   = mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b10, 0);
    JR    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0);

    // addi: 4 cycles
    add(6'b001000, 0, 1, F1, 0);  add(6'b001000, 0, 1, DEC, 0);
    add(6'b001000, 0, 1, EXADD, 0); add(6'b001000, 0, 1, WBI, 0);
    // lw with two MEM_RD wait cycles: 7 cycles
    add(6'b100011, 0, 1, F1, 1);  add(6'b100011, 0, 1, DEC, 1);  add(6'b100011, 0, 1, MADR, 1);
    add(6'b100011, 0, 0, MRD, 1); add(6'b100011, 0, 0, MRD, 1);  add(6'b100011, 0, 1, MRD, 1);
    add(6'b100011, 0, 1, MWB, 1);
    // sw with one FETCH wait and one MEM_WR wait
    add(6'b101011, 0, 0, F0, 2);  add(6'b101011, 0, 1, F1, 2);   add(6'b101011, 0, 1, DEC, 2);
    add(6'b101011, 0, 1, MADR, 2); add(6'b101011, 0, 0, MWR, 2); add(6'b101011, 0, 1, MWR, 2);
    // R and andi
    add(6'b000000, 0, 1, F1, 3);  add(6'b000000, 0, 1, DEC, 3);  add(6'b000000, 0, 1, EXR, 3);
    add(6'b000000, 0, 1, WBR, 3);
    add(6'b001100, 0, 1, F1, 4);  add(6'b001100, 0, 1, DEC, 4);  add(6'b001100, 0, 1, EXAND, 4);
    add(6'b001100, 0, 1, WBI, 4);
    // branches: beq z1 taken, bne z1 not, beq z0 not, bne z0 taken
    add(6'b000100, 1, 1, F1, 5);  add(6'b000100, 1, 1, DEC, 5);  add(6'b000100, 1, 1, BRT, 5);
    add(6'b000101, 1, 1, F1, 6);  add(6'b000101, 1, 1, DEC, 6);  add(6'b000101, 1, 1, BRN, 6);
    add(6'b000100, 0, 1, F1, 7);  add(6'b000100, 0, 1, DEC, 7);  add(6'b000100, 0, 1, BRN, 7);
    add(6'b000101, 0, 1, F1, 8);  add(6'b000101, 0, 1, DEC, 8);  add(6'b000101, 0, 1, BRT, 8);
    // jumps
    add(6'b000010, 0, 1, F1, 9);  add(6'b000010, 0, 1, DEC, 9);  add(6'b000010, 0, 1, JJ, 9);
    add(6'b000011, 0, 1, F1, 10); add(6'b000011, 0, 1, DEC, 10); add(6'b000011, 0, 1, JAL, 10);
    add(6'b000001, 0, 1, F1, 11); add(6'b000001, 0, 1, DEC, 11); add(6'b000001, 0, 1, JR, 11);
    // illegal opcode: 2 cycles, not counted
    add(6'b111111, 0, 1, F1, 12); add(6'b111111, 0, 1, DILL, 12);
    // sw parked in MEM_WR wait for the reset case below
    add(6'b101011, 0, 1, F1, 12); add(6'b101011, 0, 1, DEC, 12); add(6'b101011, 0, 1, MADR, 12);
    add(6'b101011, 0, 0, MWR, 12);

    rst_n = 1'b0; rst2_n = 1'b0;
    opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    opcode2 = 6'b000000; mem_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 0, F1, 16'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      opcode = tbl[i].opc; zero = tbl[i].z; mem_ready = tbl[i].rdy;
      #3;
      chk("vec", i, tbl[i].exp, tbl[i].cnt);
      @(posedge clk);
      #1;
    end

    // still stalled in MEM_WR; async reset abandons the write immediately
    chk("mw_hold", 0, MWR, 16'd12);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 0, F0, 16'd0);
    @(posedge clk);
    #1;
    chk("rst_held", 0, F0, 16'd0);
    rst_n = 1'b1;

    // MEM_HANDSHAKE=0, CNT_W=2, mem_ready tied low: R-type still 4 cycles
    @(posedge clk);
    #1;
    rst2_n = 1'b1;
    #1;
    chk2("nohs_fetch", 2'd0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk2("nohs_r1", 2'd1, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    chk2("wrap_r4", 2'd0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk2("wrap_r5", 2'd1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
